// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_arbiter_if : processor, display and RAM signals of the data-memory arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter : single-port data memory shared by processor and display engine
//                (display priority; starvation guard under DMEM_ARB_STARVE_GUARD_EN)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave mem_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    CPU_WR  = 2'd2,
    DISP_RD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic              cpu_gnt;
  logic              disp_gnt;
  logic              force_cpu;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (!mem_bus.cpu_req || cpu_gnt) begin
      wait_d = '0;
    end else if (wait_q != CNT_W'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign force_cpu = (wait_q == CNT_W'(MAX_WAIT));
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign force_cpu       = 1'b0;
`endif

  // Grants are suppressed while rst is high so a read issued then never returns.
  always_comb begin
    cpu_gnt    = 1'b0;
    disp_gnt   = 1'b0;
    state_d    = IDLE;
    ram_addr_d = ram_addr_q;
    if (!rst) begin
      if (mem_bus.disp_req && !(mem_bus.cpu_req && force_cpu)) begin
        disp_gnt = 1'b1;
      end else if (mem_bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
    if (disp_gnt) begin
      state_d    = DISP_RD;
      ram_addr_d = mem_bus.disp_addr;
    end else if (cpu_gnt) begin
      state_d    = mem_bus.cpu_we ? CPU_WR : CPU_RD;
      ram_addr_d = mem_bus.cpu_addr;
    end
  end

  always_comb begin
    cpu_rdata_d  = cpu_rdata_q;
    disp_rdata_d = disp_rdata_q;
    if (state_q == CPU_RD) begin
      cpu_rdata_d = mem_bus.ram_rdata;
    end
    if (state_q == DISP_RD) begin
      disp_rdata_d = mem_bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      cpu_rdata_q  <= '0;
      disp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      cpu_rdata_q  <= cpu_rdata_d;
      disp_rdata_q <= disp_rdata_d;
    end
  end

  assign mem_bus.cpu_gnt     = cpu_gnt;
  assign mem_bus.disp_gnt    = disp_gnt;
  assign mem_bus.ram_addr    = ram_addr_d;
  assign mem_bus.ram_we      = cpu_gnt & mem_bus.cpu_we;
  assign mem_bus.ram_wdata   = mem_bus.cpu_wdata;
  assign mem_bus.cpu_rvalid  = (state_q == CPU_RD);
  assign mem_bus.disp_rvalid = (state_q == DISP_RD);
  assign mem_bus.cpu_rdata   = cpu_rdata_d;
  assign mem_bus.disp_rdata  = disp_rdata_d;

endmodule

`default_nettype wire
